arf_variance_monitor: RTL
=========================

Name: arf_variance_monitor

Overview:
- Sequential consumer of the ARF datapath outputs: reads paired exact/approximate results for both filter outputs (out_27, out_28 channels) over a window of 2^LOG_N samples.
- Computes per-channel error mean and variance and returns them through a valid/ready result port.
- Sits downstream of the approximate ARF netlist in the characterisation harness; it measures in hardware the error variance the DFG flow predicts.

Parameters:
- W, 16, width of each ARF output sample (two's complement).
- LOG_N, 4, log2 of window length; N = 2^LOG_N samples per measurement (1..8 legal).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a window when IDLE, ignored otherwise.
- in_valid  in  1  sample pair present.
- in_ready  out  1  block accepts a sample this cycle.
- exact0, approx0  in  W  exact/approximate sample, channel 0 (out_27).
- exact1, approx1  in  W  exact/approximate sample, channel 1 (out_28).
- res_valid  out  1  results valid, held until accepted.
- res_ready  in  1  consumer accepts results.
- mean0, mean1  out  W+1  signed error mean per channel.
- var0, var1  out  2W+2  unsigned error variance per channel.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; in_ready=0, res_valid=0, busy=0, mean*/var*=0, accumulators and count=0. Reset mid-window discards all partial sums.
- Error: eK = approxK - exactK, sign-extended to W+1 bits (no overflow possible).
- Accumulators per channel: sumK signed W+1+LOG_N; sqK unsigned 2W+2+LOG_N; sized so N worst-case samples never overflow.
- States: IDLE, ACC, MEAN, VAR, OUT.
- IDLE: on start, clear sums and count, go to ACC.
- ACC: in_ready=1. Transfer on in_valid&in_ready: sumK += eK, sqK += eK*eK, count++. When the transfer with count==N-1 occurs, go to MEAN. No sample is accepted outside ACC.
- MEAN: meanK <= sumK >>> LOG_N (arithmetic shift, floor toward -inf). One cycle, then VAR.
- VAR: t = (sqK >> LOG_N) - meanK*meanK. varK <= t if t>=0, else 0 (clamp; arises from floor rounding). One cycle, then OUT.
- OUT: res_valid=1. Outputs stable until res_ready. On res_valid&res_ready go to IDLE and drop res_valid next cycle.
- Latency: res_valid rises 2 cycles after the clock edge that accepts the last sample.
- Simultaneous events:
  - start in OUT is ignored; it is not queued.
  - start and res_ready together in OUT: accept results and go to IDLE; no new window starts.
- mean*/var* are held between windows; they update only in MEAN/VAR.
- in_valid may stay high while in_ready=0; no sample is lost or duplicated across the IDLE->ACC edge (in_ready is registered from state).

Decomposition:
- Shared package arf_pkg: state enum (IDLE, ACC, MEAN, VAR, OUT), width helper constants (err width W+1, square width 2W+2, accumulator widths as functions of W and LOG_N).
- One sub-module, arf_err_stat: per-channel error, sum/square accumulation, mean/var registers with clamp. Instantiated twice. Top holds the FSM, counter and handshakes.

Test Plan (W=16, LOG_N=2, N=4):
- Constant error: approx0-exact0 = 1,1,1,1 -> mean0=1, var0=0; res_valid exactly 2 cycles after 4th accept.
- Symmetric error, channel 1: e1 = 2,-2,2,-2 -> mean1=0, var1=4; channel 0 all zero -> mean0=0, var0=0.
- Floor clamp: e0 = -3,-3,-3,-2 -> sum=-11, mean0=-3, sq>>2=7, 7-9<0 -> var0=0.
- Backpressure: in_valid toggled 1,0,1,0...; hold res_ready=0 for 5 cycles in OUT -> exactly 4 samples counted, outputs and res_valid stable until handshake, then IDLE.
- Extremes: approx0=32767, exact0=-32768 for 4 samples -> mean0=65535, var0=0, no overflow. start pulsed during ACC ignored.
- Reset mid-window: rst_n low after 2 samples, then new start with e0 = 4,0,4,0 -> mean0=2, var0=4 (no stale sums).

Source files
------------

// File: rtl/arf_pkg.sv
// rtl/arf_pkg.sv - shared types and width helpers for the ARF variance monitor
//
// Purpose: state encoding for the monitor FSM and width functions that tie the
// error, square and accumulator widths to W (sample width) and LOG_N (window).
package arf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    MEAN,
    VAR,
    OUT
  } arf_state_e;

  // Difference of two W-bit two's complement values always fits in W+1 bits.
  function automatic int err_w(input int w);
    return w + 1;
  endfunction

  // Square of a (W+1)-bit signed error, stored as 2W+2 bits.
  function automatic int sq_w(input int w);
    return 2 * w + 2;
  endfunction

  // Signed error sum over 2^LOG_N samples.
  function automatic int sum_w(input int w, input int log_n);
    return w + 1 + log_n;
  endfunction

  // Unsigned square sum over 2^LOG_N samples.
  function automatic int sqacc_w(input int w, input int log_n);
    return 2 * w + 2 + log_n;
  endfunction

endpackage

// File: rtl/arf_err_stat.sv
// rtl/arf_err_stat.sv - per-channel error accumulation, mean and clamped variance
//
// Purpose: forms e = approx - exact, accumulates sum(e) and sum(e*e) over a
// window, then computes mean = floor(sum / N) and var = sum(e*e)/N - mean^2
// (clamped at zero) in two separate cycles under control of the parent FSM.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            zero both accumulators (window start)
//   acc_en           accumulate the current sample pair
//   mean_en          load mean from the error sum
//   var_en           load variance from the square sum and registered mean
//   exact, approx    W-bit two's complement sample pair
//   mean             signed W+1-bit error mean (held between windows)
//   variance         unsigned 2W+2-bit error variance (held between windows)
module arf_err_stat
  import arf_pkg::*;
#(
  parameter int W     = 16,
  parameter int LOG_N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                acc_en,
  input  logic                mean_en,
  input  logic                var_en,
  input  logic [W-1:0]        exact,
  input  logic [W-1:0]        approx,
  output logic signed [W:0]   mean,
  output logic [2*W+1:0]      variance
);

  localparam int EW   = err_w(W);
  localparam int SQW  = sq_w(W);
  localparam int SUMW = sum_w(W, LOG_N);
  localparam int SQAW = sqacc_w(W, LOG_N);

  logic signed [EW-1:0]   err;
  logic signed [SQW-1:0]  err_x;
  logic signed [SQW-1:0]  err_sq_s;
  logic [SQW-1:0]         err_sq;
  logic signed [SUMW-1:0] err_acc_x;

  logic signed [SUMW-1:0] sum;
  logic [SQAW-1:0]        sq;

  logic signed [SQW:0]    mean_x;
  logic signed [SQW:0]    mean_sq;
  logic signed [SQW:0]    sq_mean;
  logic signed [SQW:0]    var_t;

  assign err       = $signed({approx[W-1], approx}) - $signed({exact[W-1], exact});
  assign err_x     = {{(SQW - EW){err[EW-1]}}, err};
  assign err_sq_s  = err_x * err_x;
  assign err_sq    = err_sq_s;
  assign err_acc_x = {{(SUMW - EW){err[EW-1]}}, err};

  // The variance step uses the registered mean, so mean must be loaded one
  // cycle earlier. Both operands fit in SQW bits; one extra sign bit lets the
  // difference go negative, which only happens through floor rounding of mean.
  assign mean_x  = {{(SQW + 1 - EW){mean[EW-1]}}, mean};
  assign mean_sq = mean_x * mean_x;
  assign sq_mean = {1'b0, SQW'(sq >> LOG_N)};
  assign var_t   = sq_mean - mean_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      sq       <= '0;
      mean     <= '0;
      variance <= '0;
    end else begin
      if (clear) begin
        sum <= '0;
        sq  <= '0;
      end else if (acc_en) begin
        sum <= sum + err_acc_x;
        sq  <= sq + {{LOG_N{1'b0}}, err_sq};
      end
      if (mean_en) begin
        // Arithmetic shift floors toward -inf; the quotient always fits EW bits.
        mean <= EW'(sum >>> LOG_N);
      end
      if (var_en) begin
        variance <= var_t[SQW] ? '0 : var_t[SQW-1:0];
      end
    end
  end

endmodule

// File: rtl/arf_variance_monitor.sv
// rtl/arf_variance_monitor.sv - windowed error mean/variance monitor for ARF outputs
//
// Purpose: accepts 2^LOG_N exact/approx sample pairs for two ARF output channels
// (out_27 -> channel 0, out_28 -> channel 1), then reports per-channel error
// mean and variance through a valid/ready result port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a window (honoured only in IDLE)
//   in_valid / in_ready        sample pair handshake (in_ready high only in ACC)
//   exact0, approx0            channel 0 samples
//   exact1, approx1            channel 1 samples
//   res_valid / res_ready      result handshake, results held until accepted
//   mean0, mean1               signed error means
//   var0, var1                 unsigned error variances
//   busy                       high whenever the FSM is not IDLE
module arf_variance_monitor
  import arf_pkg::*;
#(
  parameter int W     = 16,
  parameter int LOG_N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        exact0,
  input  logic [W-1:0]        approx0,
  input  logic [W-1:0]        exact1,
  input  logic [W-1:0]        approx1,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [W:0]   mean0,
  output logic signed [W:0]   mean1,
  output logic [2*W+1:0]      var0,
  output logic [2*W+1:0]      var1,
  output logic                busy
);

  localparam logic [LOG_N-1:0] LAST = '1;

  arf_state_e       state;
  logic [LOG_N-1:0] count;
  logic             take;
  logic             clear;
  logic             mean_en;
  logic             var_en;

  assign take    = in_valid & in_ready;
  assign clear   = (state == IDLE) & start;
  assign mean_en = (state == MEAN);
  assign var_en  = (state == VAR);

  // in_ready, res_valid and busy are registered alongside the state so that
  // in_ready rises only on the cycle after IDLE->ACC; a sample held on
  // in_valid across that edge is taken exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (take) begin
            count <= count + 1'b1;
            if (count == LAST) begin
              state    <= MEAN;
              in_ready <= 1'b0;
            end
          end
        end
        MEAN: begin
          state <= VAR;
        end
        VAR: begin
          state     <= OUT;
          res_valid <= 1'b1;
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  arf_err_stat #(
    .W     (W),
    .LOG_N (LOG_N)
  ) u_stat0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .acc_en   (take),
    .mean_en  (mean_en),
    .var_en   (var_en),
    .exact    (exact0),
    .approx   (approx0),
    .mean     (mean0),
    .variance (var0)
  );

  arf_err_stat #(
    .W     (W),
    .LOG_N (LOG_N)
  ) u_stat1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .acc_en   (take),
    .mean_en  (mean_en),
    .var_en   (var_en),
    .exact    (exact1),
    .approx   (approx1),
    .mean     (mean1),
    .variance (var1)
  );

endmodule
